// File: rtl/rgb_hue_pkg.sv
// Shared types, constants and the hue-wheel to RGB duty mapping for the RGB hue sweeper.
package rgb_hue_pkg;

  localparam int CLK_HZ_DEFAULT   = 12000000;
  localparam int PWM_BITS_DEFAULT = 8;
  localparam int HUE_MAX          = 6 * (2 ** PWM_BITS_DEFAULT) - 1;
  localparam int HUE_HALF         = (HUE_MAX + 1) / 2;

  typedef logic [PWM_BITS_DEFAULT-1:0] duty_t;
  typedef logic [10:0]                 hue_t;

  typedef struct packed {
    duty_t r;
    duty_t g;
    duty_t b;
  } rgb_duty_t;

  localparam duty_t DUTY_OFF  = '0;
  localparam duty_t DUTY_FULL = '1;

  // Six sectors of 256 steps each; inside a sector one channel ramps while the others are pinned.
  function automatic rgb_duty_t hue_to_duty(input hue_t hue);
    rgb_duty_t d;
    duty_t     f;
    f = hue[7:0];
    d = '{r: DUTY_OFF, g: DUTY_OFF, b: DUTY_OFF};
    case (hue[10:8])
      3'd0: d = '{r: DUTY_FULL, g: f,         b: DUTY_OFF};
      3'd1: d = '{r: ~f,        g: DUTY_FULL, b: DUTY_OFF};
      3'd2: d = '{r: DUTY_OFF,  g: DUTY_FULL, b: f};
      3'd3: d = '{r: DUTY_OFF,  g: ~f,        b: DUTY_FULL};
      3'd4: d = '{r: f,         g: DUTY_OFF,  b: DUTY_FULL};
      3'd5: d = '{r: DUTY_FULL, g: DUTY_OFF,  b: ~f};
      default: d = '{r: DUTY_OFF, g: DUTY_OFF, b: DUTY_OFF};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM colour channel: registered, active-low compare of the shared counter against a duty.
import rgb_hue_pkg::*;

module pwm_channel (
  input  logic  clk,
  input  logic  SW,
  input  duty_t pwm_cnt,
  input  duty_t duty,
  output logic  led_n
);

  always_ff @(posedge clk) begin
    if (SW) begin
      led_n <= 1'b1;
    end else begin
      led_n <= ~(pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/rgb_hue_top.sv
// Board top: sweeps the RGB LED around the hue wheel, with a half-cycle status LED and BOOT pause.
import rgb_hue_pkg::*;

module rgb_hue_top #(
  parameter int CLK_HZ    = CLK_HZ_DEFAULT,
  parameter int PWM_BITS  = PWM_BITS_DEFAULT,
  parameter int STEP_CLKS = CLK_HZ / (6 * (2 ** PWM_BITS))
) (
  input  logic clk,
  input  logic SW,
  input  logic BOOT,
  output logic LED,
  output logic RGB_R,
  output logic RGB_G,
  output logic RGB_B
);

  localparam int STEP_W = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CLKS - 1);

  logic [1:0]        boot_sync_reg;
  logic [STEP_W-1:0] step_cnt_reg;
  hue_t              hue_reg;
  duty_t             pwm_cnt_reg;
  logic              led_reg;
  logic              pause;
  rgb_duty_t         duty;

  assign pause = boot_sync_reg[1];
  assign duty  = hue_to_duty(hue_reg);
  assign LED   = led_reg;

  always_ff @(posedge clk) begin
    if (SW) begin
      boot_sync_reg <= '0;
      step_cnt_reg  <= '0;
      hue_reg       <= '0;
      pwm_cnt_reg   <= '0;
      led_reg       <= 1'b0;
    end else begin
      boot_sync_reg <= {boot_sync_reg[0], BOOT};
      pwm_cnt_reg   <= pwm_cnt_reg + duty_t'(1);
      led_reg       <= (hue_reg < hue_t'(HUE_HALF));
      // Pausing freezes only the hue timebase; PWM keeps running so the colour stays steady.
      if (!pause) begin
        if (step_cnt_reg == STEP_LAST) begin
          step_cnt_reg <= '0;
          hue_reg      <= (hue_reg == hue_t'(HUE_MAX)) ? hue_t'(0) : hue_reg + hue_t'(1);
        end else begin
          step_cnt_reg <= step_cnt_reg + STEP_W'(1);
        end
      end
    end
  end

  pwm_channel u_red (
    .clk     (clk),
    .SW      (SW),
    .pwm_cnt (pwm_cnt_reg),
    .duty    (duty.r),
    .led_n   (RGB_R)
  );

  pwm_channel u_green (
    .clk     (clk),
    .SW      (SW),
    .pwm_cnt (pwm_cnt_reg),
    .duty    (duty.g),
    .led_n   (RGB_G)
  );

  pwm_channel u_blue (
    .clk     (clk),
    .SW      (SW),
    .pwm_cnt (pwm_cnt_reg),
    .duty    (duty.b),
    .led_n   (RGB_B)
  );

endmodule

// File: tb/tb_rgb_hue_top.sv
// Directed bench for rgb_hue_top with a 4-clock hue step; expected values are hand-derived.
module tb_rgb_hue_top;

  logic clk = 1'b0;
  logic SW = 1'b1;
  logic BOOT = 1'b0;
  logic LED, RGB_R, RGB_G, RGB_B;

  int compared = 0;
  int mismatched = 0;
  int low_r, low_g, low_b;

  rgb_hue_top #(.STEP_CLKS(4)) dut (
    .clk   (clk),
    .SW    (SW),
    .BOOT  (BOOT),
    .LED   (LED),
    .RGB_R (RGB_R),
    .RGB_G (RGB_G),
    .RGB_B (RGB_B)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
    $display("check %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  // Counts clocks each channel spends lit (pin low) over a window.
  task automatic measure(input int n);
    low_r = 0; low_g = 0; low_b = 0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (RGB_R === 1'b0) low_r++;
      if (RGB_G === 1'b0) low_g++;
      if (RGB_B === 1'b0) low_b++;
    end
  endtask

  initial begin
    // Reset held for three clocks
    tick(3);
    check("reset_r", 32'(RGB_R), 32'd1);
    check("reset_g", 32'(RGB_G), 32'd1);
    check("reset_b", 32'(RGB_B), 32'd1);
    check("reset_led", 32'(LED), 32'd0);
    check("reset_hue", 32'(dut.hue_reg), 32'd0);

    // Release: first edge after release shows hue 0 (red full, green/blue off)
    SW = 1'b0;
    tick(1);                                   // total steps = 1
    check("release_led", 32'(LED), 32'd1);
    check("release_r", 32'(RGB_R), 32'd0);
    check("release_g", 32'(RGB_G), 32'd1);
    check("release_b", 32'(RGB_B), 32'd1);

    // Window over steps 1..256: red lit except at pwm=255, green lit only once (pwm 0 < f 64)
    measure(256);                              // total steps = 257
    check("sweep_low_r", 32'(low_r), 32'd255);
    check("sweep_low_g", 32'(low_g), 32'd1);
    check("sweep_low_b", 32'(low_b), 32'd0);

    // Pause so hue lands on 300 (2 more steps slip through the synchronizer)
    tick(941);                                 // total steps = 1198
    BOOT = 1'b1;
    tick(10);                                  // steps stop at 1200 -> hue 300
    check("pause_hue", 32'(dut.hue_reg), 32'd300);
    measure(256);
    check("pause_low_r", 32'(low_r), 32'd211);
    check("pause_low_g", 32'(low_g), 32'd255);
    check("pause_low_b", 32'(low_b), 32'd0);
    tick(1000);
    check("pause_hold_hue", 32'(dut.hue_reg), 32'd300);
    check("pause_led", 32'(LED), 32'd1);

    // Release: stepping resumes on the 3rd edge, so 9 steps in 11 clocks
    BOOT = 1'b0;
    tick(11);                                  // total steps = 1209
    check("resume_hue", 32'(dut.hue_reg), 32'd302);

    // LED falls one clock after hue reaches 768
    tick(1863);                                // total steps = 3072
    check("half_hue", 32'(dut.hue_reg), 32'd768);
    check("half_led_before", 32'(LED), 32'd1);
    tick(1);
    check("half_led_after", 32'(LED), 32'd0);
    check("half_r_off", 32'(RGB_R), 32'd1);

    // Wrap 1535 -> 0, LED rises one clock later
    tick(3071);                                // total steps = 6144
    check("wrap_hue", 32'(dut.hue_reg), 32'd0);
    check("wrap_led_before", 32'(LED), 32'd0);
    tick(1);
    check("wrap_led_after", 32'(LED), 32'd1);

    // Mid-cycle reset at hue 900
    tick(3599);                                // total steps = 9744
    check("mid_hue", 32'(dut.hue_reg), 32'd900);
    SW = 1'b1;
    tick(1);
    check("mid_reset_hue", 32'(dut.hue_reg), 32'd0);
    check("mid_reset_pwm", 32'(dut.pwm_cnt_reg), 32'd0);
    check("mid_reset_r", 32'(RGB_R), 32'd1);
    check("mid_reset_g", 32'(RGB_G), 32'd1);
    check("mid_reset_b", 32'(RGB_B), 32'd1);
    check("mid_reset_led", 32'(LED), 32'd0);
    SW = 1'b0;
    tick(1);
    check("restart_r", 32'(RGB_R), 32'd0);
    check("restart_led", 32'(LED), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
